// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encodings, the
// per-beat side-band record and the slice configuration check.
package adder_pipe_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SAT = 2'b10;

  // Side-band travelling with each beat; the result is fixed up from it at the end.
  typedef struct packed {
    logic sub;
    logic sat;
    logic a_msb;
    logic b_msb;
  } meta_t;

  function automatic bit slice_cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_pipe_slice.sv
// One carry slice of the pipelined adder: CW-bit add whose sum, carry-out and
// valid are registered and advance only while en is high.
module adder_pipe_slice #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic          out_valid,
  output logic [CW-1:0] sum,
  output logic          cout
);

  logic [CW:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      sum       <= total[CW-1:0];
      cout      <= total[CW];
    end
  end

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit add / subtract-with-borrow / saturating add built from
// STAGES carry-registered slices, with valid/ready handshakes on both sides.
module adder_pipe_nbit
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int CW = WIDTH / STAGES;

  if (!slice_cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("adder_pipe_nbit: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             advance;
  logic             accept;
  logic             is_sub;
  logic             is_sat;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [STAGES-1:0] valid_s;
  logic [STAGES-1:0] carry_s;
  logic [WIDTH-1:0] sum_aligned;
  meta_t            meta_dly [STAGES];
  meta_t            meta_out;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign is_sub   = (in_op == OP_SUB);
  assign is_sat   = (in_op == OP_SAT);
  // Subtraction runs as A + ~B + ~C so every slice is a plain adder.
  assign b_eff    = is_sub ? ~in_b : in_b;
  assign c_eff    = is_sub ? ~in_c : in_c;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slice
      logic [CW-1:0] a_s;
      logic [CW-1:0] b_s;
      logic [CW-1:0] sum_s;
      logic          cin_s;
      logic          vin_s;

      if (gi == 0) begin : g_head
        assign a_s   = in_a[CW-1:0];
        assign b_s   = b_eff[CW-1:0];
        assign cin_s = c_eff;
        assign vin_s = accept;
      end else begin : g_skew
        // Operand slice gi waits gi cycles for the carry from the slice below.
        logic [CW-1:0] a_dly [gi];
        logic [CW-1:0] b_dly [gi];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < gi; i++) begin
              a_dly[i] <= '0;
              b_dly[i] <= '0;
            end
          end else if (advance) begin
            a_dly[0] <= in_a[gi*CW +: CW];
            b_dly[0] <= b_eff[gi*CW +: CW];
            for (int i = 1; i < gi; i++) begin
              a_dly[i] <= a_dly[i-1];
              b_dly[i] <= b_dly[i-1];
            end
          end
        end

        assign a_s   = a_dly[gi-1];
        assign b_s   = b_dly[gi-1];
        assign cin_s = carry_s[gi-1];
        assign vin_s = valid_s[gi-1];
      end

      adder_pipe_slice #(.CW(CW)) u_slice (
        .clk       (clk),
        .rst       (rst),
        .en        (advance),
        .in_valid  (vin_s),
        .a         (a_s),
        .b         (b_s),
        .cin       (cin_s),
        .out_valid (valid_s[gi]),
        .sum       (sum_s),
        .cout      (carry_s[gi])
      );

      if (gi == STAGES - 1) begin : g_last
        assign sum_aligned[gi*CW +: CW] = sum_s;
      end else begin : g_deskew
        // Lower result slices finish early and wait here for the top slice.
        logic [CW-1:0] sum_dly [STAGES-1-gi];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < STAGES - 1 - gi; i++) sum_dly[i] <= '0;
          end else if (advance) begin
            sum_dly[0] <= sum_s;
            for (int i = 1; i < STAGES - 1 - gi; i++) sum_dly[i] <= sum_dly[i-1];
          end
        end

        assign sum_aligned[gi*CW +: CW] = sum_dly[STAGES-2-gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) meta_dly[i] <= '0;
    end else if (advance) begin
      meta_dly[0] <= '{sub: is_sub, sat: is_sat, a_msb: in_a[WIDTH-1], b_msb: b_eff[WIDTH-1]};
      for (int i = 1; i < STAGES; i++) meta_dly[i] <= meta_dly[i-1];
    end
  end

  assign meta_out  = meta_dly[STAGES-1];
  assign out_valid = valid_s[STAGES-1];
  assign out_sum   = (meta_out.sat && carry_s[STAGES-1]) ? '1 : sum_aligned;
  assign out_carry = meta_out.sub ? ~carry_s[STAGES-1] : carry_s[STAGES-1];
  // Overflow is judged on the unsaturated sum.
  assign out_ovf   = (meta_out.a_msb == meta_out.b_msb) &&
                     (sum_aligned[WIDTH-1] != meta_out.a_msb);

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Self-checking bench for adder_pipe_nbit: scoreboard-driven checks on an
// 8-bit/2-stage instance plus a 16-bit/4-stage instance for latency scaling.
module tb_adder_pipe_nbit;
  import adder_pipe_pkg::*;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int W2 = 16;
  localparam int S2 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_c, out_valid, out_ready, out_carry, out_ovf;
  logic [W-1:0] in_a, in_b, out_sum;
  logic [1:0]   in_op;

  logic          w_in_valid, w_in_ready, w_in_c, w_out_valid, w_out_ready, w_out_carry, w_out_ovf;
  logic [W2-1:0] w_in_a, w_in_b, w_out_sum;
  logic [1:0]    w_in_op;

  adder_pipe_nbit #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf)
  );

  adder_pipe_nbit #(.WIDTH(W2), .STAGES(S2)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b), .in_c(w_in_c), .in_op(w_in_op),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_sum(w_out_sum), .out_carry(w_out_carry), .out_ovf(w_out_ovf)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } res_t;

  typedef struct {
    res_t res;
    int   cyc;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Directed vectors with their hand-derived results.
  logic [7:0] va   [6] = '{8'h64, 8'hAA, 8'h10, 8'h12, 8'hBF, 8'h10};
  logic [7:0] vb   [6] = '{8'h3C, 8'hAD, 8'h12, 8'h10, 8'hAD, 8'h12};
  logic       vc   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] vop  [6] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SAT, OP_SAT};
  res_t       vexp [6] = '{{8'hA0, 1'b0, 1'b1}, {8'h58, 1'b1, 1'b1}, {8'hFE, 1'b1, 1'b0},
                           {8'h01, 1'b0, 1'b0}, {8'hFF, 1'b1, 1'b1}, {8'h23, 1'b0, 1'b0}};

  logic [15:0] wa   [4] = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'hFFF0};
  logic [15:0] wb   [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0020};
  logic [1:0]  wop  [4] = '{OP_ADD, OP_ADD, OP_SUB, OP_SAT};
  logic [17:0] wexp [4] = '{{16'h0000, 1'b1, 1'b0}, {16'h8000, 1'b0, 1'b1},
                            {16'hFFFF, 1'b1, 1'b0}, {16'hFFFF, 1'b1, 1'b0}};

  logic [7:0] ra [8];
  logic [7:0] rb [8];
  logic       rc [8];
  logic [1:0] rop[8];

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic c,
                                 input logic [1:0] op);
    res_t       r;
    logic [8:0] t;
    if (op == OP_SUB) begin
      r.sum   = a - b - {7'd0, c};
      r.carry = ({1'b0, a} < ({1'b0, b} + {8'd0, c}));
      r.ovf   = (a[7] != b[7]) && (r.sum[7] != a[7]);
    end else begin
      t       = {1'b0, a} + {1'b0, b} + {8'd0, c};
      r.sum   = t[7:0];
      r.carry = t[8];
      r.ovf   = (a[7] == b[7]) && (t[7] != a[7]);
      if (op == OP_SAT && t[8]) r.sum = 8'hFF;
    end
    return r;
  endfunction

  // Called on a falling edge: drives one cycle, samples, scores, returns on the next falling edge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [1:0] op, input logic ordy,
                      output logic acc, output logic got, output logic rdy,
                      output res_t exp, output res_t obs, output int lat);
    sb_t e;
    in_valid = v; in_a = a; in_b = b; in_c = c; in_op = op; out_ready = ordy;
    #1;
    rdy = in_ready;
    acc = v && in_ready;
    got = out_valid && out_ready;
    obs = {out_sum, out_carry, out_ovf};
    exp = 'x;
    lat = -1;
    if (got && sb.size() > 0) begin
      e   = sb.pop_front();
      exp = e.res;
      lat = cyc - e.cyc;
    end
    if (acc) sb.push_back('{model(a, b, c, op), cyc});
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold_valid: out_valid=%b, required 0", out_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sum, out_carry, out_ovf} !== '0) begin
      errors++; $display("FAIL reset_outputs: valid=%b sum=%h carry=%b ovf=%b, required all 0",
                         out_valid, out_sum, out_carry, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
    end
    checks++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1 || w_out_sum !== '0) begin
      errors++; $display("FAIL reset_wide: valid=%b ready=%b sum=%h, required 0 1 0000",
                         w_out_valid, w_in_ready, w_out_sum);
    end
    $display("reset: out_valid=%b in_ready=%b", out_valid, in_ready);
    @(negedge clk);
  endtask

  task automatic test_vectors;
    logic acc, got, rdy, done;
    res_t exp, obs;
    int   lat;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, va[k], vb[k], vc[k], vop[k], 1'b1, acc, got, rdy, exp, obs, lat);
      done = 1'b0;
      for (int t = 0; t < 8 && !done; t++) begin
        step(1'b0, 8'h00, 8'h00, 1'b0, OP_ADD, 1'b1, acc, got, rdy, exp, obs, lat);
        if (got) begin
          done = 1'b1;
          checks++;
          if (obs !== vexp[k]) begin
            errors++; $display("FAIL vec%0d_result: got sum=%h carry=%b ovf=%b, required sum=%h carry=%b ovf=%b",
                               k, obs.sum, obs.carry, obs.ovf, vexp[k].sum, vexp[k].carry, vexp[k].ovf);
          end
          checks++;
          if (lat !== S) begin
            errors++; $display("FAIL vec%0d_latency: got %0d cycles, required %0d", k, lat, S);
          end
          $display("vec%0d: a=%h b=%h c=%b op=%0d -> sum=%h carry=%b ovf=%b lat=%0d",
                   k, va[k], vb[k], vc[k], vop[k], obs.sum, obs.carry, obs.ovf, lat);
        end
      end
      checks++;
      if (!done) begin
        errors++; $display("FAIL vec%0d_timeout: no result within 8 cycles, required one", k);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic acc, got, rdy;
    res_t exp, obs;
    int   lat, i, n_out, first_oc, oc;
    for (int k = 0; k < 8; k++) begin
      ra[k] = 8'($urandom); rb[k] = 8'($urandom); rc[k] = 1'($urandom); rop[k] = 2'($urandom_range(0, 3));
    end
    i = 0; n_out = 0; first_oc = 0;
    for (int t = 0; t < 30 && n_out < 8; t++) begin
      oc = cyc;
      step(i < 8, ra[i % 8], rb[i % 8], rc[i % 8], rop[i % 8], 1'b1, acc, got, rdy, exp, obs, lat);
      if (acc) i++;
      if (got) begin
        if (n_out == 0) first_oc = oc;
        checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL b2b%0d_result: got sum=%h carry=%b ovf=%b, required sum=%h carry=%b ovf=%b",
                             n_out, obs.sum, obs.carry, obs.ovf, exp.sum, exp.carry, exp.ovf);
        end
        checks++;
        if (lat !== S || oc !== first_oc + n_out) begin
          errors++; $display("FAIL b2b%0d_timing: latency %0d slot %0d, required latency %0d slot %0d",
                             n_out, lat, oc - first_oc, S, n_out);
        end
        $display("b2b%0d: sum=%h carry=%b ovf=%b lat=%0d", n_out, obs.sum, obs.carry, obs.ovf, lat);
        n_out++;
      end
    end
    checks++;
    if (n_out !== 8 || sb.size() !== 0) begin
      errors++; $display("FAIL b2b_count: got %0d results with %0d pending, required 8 and 0", n_out, sb.size());
    end
  endtask

  task automatic test_stall;
    logic acc, got, rdy, ordy;
    res_t exp, obs, held;
    int   lat, i, n_out;
    for (int k = 0; k < 8; k++) begin
      ra[k] = 8'($urandom); rb[k] = 8'($urandom); rc[k] = 1'($urandom); rop[k] = 2'($urandom_range(0, 3));
    end
    i = 0; n_out = 0; held = '0;
    for (int t = 0; t < 40 && n_out < 8; t++) begin
      ordy = !(t >= 4 && t <= 6);
      step(i < 8, ra[i % 8], rb[i % 8], rc[i % 8], rop[i % 8], ordy, acc, got, rdy, exp, obs, lat);
      if (acc) i++;
      if (t == 4) held = obs;
      if (t >= 4 && t <= 6) begin
        checks++;
        if (rdy !== 1'b0) begin
          errors++; $display("FAIL stall_in_ready_t%0d: in_ready=%b, required 0", t, rdy);
        end
      end
      if (t >= 5 && t <= 7) begin
        checks++;
        if (obs !== held) begin
          errors++; $display("FAIL stall_hold_t%0d: got sum=%h carry=%b ovf=%b, required held sum=%h carry=%b ovf=%b",
                             t, obs.sum, obs.carry, obs.ovf, held.sum, held.carry, held.ovf);
        end
      end
      if (got) begin
        checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL stall%0d_result: got sum=%h carry=%b ovf=%b, required sum=%h carry=%b ovf=%b",
                             n_out, obs.sum, obs.carry, obs.ovf, exp.sum, exp.carry, exp.ovf);
        end
        $display("stall%0d: t=%0d sum=%h carry=%b ovf=%b", n_out, t, obs.sum, obs.carry, obs.ovf);
        n_out++;
      end
    end
    checks++;
    if (n_out !== 8 || sb.size() !== 0 || i !== 8) begin
      errors++; $display("FAIL stall_count: got %0d results, %0d sent, %0d pending, required 8 8 0",
                         n_out, i, sb.size());
    end
  endtask

  task automatic test_reset_midflight;
    logic acc, got, rdy;
    res_t exp, obs;
    int   lat;
    step(1'b1, 8'h21, 8'h43, 1'b0, OP_ADD, 1'b0, acc, got, rdy, exp, obs, lat);
    step(1'b1, 8'h55, 8'h11, 1'b1, OP_SUB, 1'b0, acc, got, rdy, exp, obs, lat);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0) begin
      errors++; $display("FAIL midflight_reset: out_valid=%b out_sum=%h, required 0 00", out_valid, out_sum);
    end
    $display("midflight: rst asserted, out_valid=%b", out_valid);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      step(1'b0, 8'h00, 8'h00, 1'b0, OP_ADD, 1'b1, acc, got, rdy, exp, obs, lat);
      checks++;
      if (got !== 1'b0) begin
        errors++; $display("FAIL midflight_stale_t%0d: out_valid=1 sum=%h, required no result", t, obs.sum);
      end
    end
  endtask

  task automatic test_wide;
    int k;
    k = 0;
    w_out_ready = 1'b1;
    for (int t = 0; t < 14; t++) begin
      if (t < 4) begin
        w_in_valid = 1'b1; w_in_a = wa[t]; w_in_b = wb[t]; w_in_c = 1'b0; w_in_op = wop[t];
      end else begin
        w_in_valid = 1'b0;
      end
      #1;
      if (w_out_valid && k < 4) begin
        checks++;
        if ({w_out_sum, w_out_carry, w_out_ovf} !== wexp[k] || t !== k + S2) begin
          errors++; $display("FAIL wide%0d: got sum=%h carry=%b ovf=%b at cycle %0d, required sum=%h carry=%b ovf=%b at cycle %0d",
                             k, w_out_sum, w_out_carry, w_out_ovf, t, wexp[k][17:2], wexp[k][1], wexp[k][0], k + S2);
        end
        $display("wide%0d: sum=%h carry=%b ovf=%b cycle=%0d", k, w_out_sum, w_out_carry, w_out_ovf, t);
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (k !== 4) begin
      errors++; $display("FAIL wide_count: got %0d results, required 4", k);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_c = 1'b0; in_op = OP_ADD; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_c = 1'b0; w_in_op = OP_ADD; w_out_ready = 1'b1;
    test_reset;
    test_vectors;
    test_back_to_back;
    test_stall;
    test_reset_midflight;
    test_wide;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
